// File: rtl/mynios2_oci_trace_pkg.sv
// Shared types and default constants for the OCI trace capture buffer.
// Imported by the RAM, the capture top and the bench.
package mynios2_oci_trace_pkg;

   localparam int DEF_DATA_W    = 30;
   localparam int DEF_COUNT_W   = 4;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_WRAP_MODE = 0;
   localparam int DEF_DROP_W    = 8;

   localparam int ENTRY_TAG_W  = DEF_COUNT_W;
   localparam int ENTRY_DATA_W = DEF_DATA_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } trace_state_t;

   // Tag sits above data, matching the {dct_count, dct_buffer} storage word.
   typedef struct packed {
      logic [ENTRY_TAG_W-1:0]  tag;
      logic [ENTRY_DATA_W-1:0] data;
   } trace_entry_t;

endpackage

// File: rtl/mynios2_oci_trace_ram.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module mynios2_oci_trace_ram
   import mynios2_oci_trace_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_DATA_W + DEF_COUNT_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mynios2_cpu_oci_trace_capture.sv
// OCI trace capture: records dct frames while capturing, freezes on test_ending
// and drains the frozen contents oldest-first over a valid/ready read port.
module mynios2_cpu_oci_trace_capture
   import mynios2_oci_trace_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int COUNT_W   = DEF_COUNT_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int WRAP_MODE = DEF_WRAP_MODE,
   parameter int DROP_W    = DEF_DROP_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       arm,
   input  logic                       dct_valid,
   input  logic [DATA_W-1:0]          dct_buffer,
   input  logic [COUNT_W-1:0]         dct_count,
   input  logic                       test_ending,
   input  logic                       test_has_ended,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [DATA_W-1:0]          rd_data,
   output logic [COUNT_W-1:0]         rd_count,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic [DROP_W-1:0]          drop_count,
   output logic                       capturing,
   output logic                       done
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int FILL_W  = $clog2(DEPTH+1);
   localparam int ENTRY_W = DATA_W + COUNT_W;
   localparam bit RING    = (WRAP_MODE != 0);

   trace_state_t state_q, state_d;

   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [FILL_W-1:0]  fill_q;
   logic [DROP_W-1:0]  drop_q;
   logic [ENTRY_W-1:0] ram_rdata;

   logic full;
   logic empty;
   logic frame_in;
   logic wr_en;
   logic overwrite;
   logic drop_evt;
   logic pop;

   assign full  = (fill_q == FILL_W'(DEPTH));
   assign empty = (fill_q == '0);

   // A full buffer either drops the new frame or, in ring mode, evicts the
   // oldest entry; both cases count as a lost frame.
   assign frame_in  = (state_q == CAPTURE) && dct_valid;
   assign wr_en     = frame_in && (!full || RING);
   assign overwrite = frame_in && full && RING;
   assign drop_evt  = frame_in && full;

   // Read handshake: rd_valid depends only on state and occupancy, never on
   // rd_ready; an entry is consumed on a rising edge where rd_valid and
   // rd_ready are both high, and rd_data/rd_count hold until that edge.
   assign rd_valid = (state_q == DRAIN) && !empty;
   assign pop      = rd_valid && rd_ready;

   always_comb begin
      state_d = state_q;
      if (arm) begin
         state_d = CAPTURE;
      end else begin
         unique case (state_q)
            IDLE: state_d = IDLE;
            CAPTURE: begin
               if (test_has_ended) begin
                  state_d = DONE;
               end else if (test_ending) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (test_has_ended || empty) begin
                  state_d = DONE;
               end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         drop_q   <= '0;
      end else begin
         state_q <= state_d;
         if (arm) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            drop_q   <= '0;
         end else begin
            if (wr_en) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            // Overwrite only happens in CAPTURE and pop only in DRAIN.
            if (overwrite || pop) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en && !full) begin
               fill_q <= fill_q + FILL_W'(1);
            end else if (pop) begin
               fill_q <= fill_q - FILL_W'(1);
            end
            if (drop_evt && (drop_q != '1)) begin
               drop_q <= drop_q + DROP_W'(1);
            end
         end
      end
   end

   mynios2_oci_trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata ({dct_count, dct_buffer}),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // Gate the head entry so the port reads zero whenever nothing is offered.
   assign rd_data    = rd_valid ? ram_rdata[DATA_W-1:0] : '0;
   assign rd_count   = rd_valid ? ram_rdata[ENTRY_W-1:DATA_W] : '0;
   assign fill_level = fill_q;
   assign drop_count = drop_q;
   assign capturing  = (state_q == CAPTURE);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_mynios2_cpu_oci_trace_capture.sv
// Bench for the OCI trace capture buffer: a stop-on-full and a ring instance
// share one stimulus stream; a vector table plus scoreboarded sequences.
module tb_mynios2_cpu_oci_trace_capture;
   import mynios2_oci_trace_pkg::*;

   localparam int DATA_W   = 30;
   localparam int COUNT_W  = 4;
   localparam int DEPTH    = 16;
   localparam int DROP_W   = 8;
   localparam int FILL_W   = $clog2(DEPTH+1);
   localparam int W        = $bits(trace_entry_t);
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset, arm, dct_valid, test_ending, test_has_ended, rd_ready;
   logic [DATA_W-1:0]   dct_buffer;
   logic [COUNT_W-1:0]  dct_count;

   logic                rv0, cap0, done0, rv1, cap1, done1;
   logic [DATA_W-1:0]   rdata0, rdata1;
   logic [COUNT_W-1:0]  rcount0, rcount1;
   logic [FILL_W-1:0]   fill0, fill1;
   logic [DROP_W-1:0]   drop0, drop1;

   mynios2_cpu_oci_trace_capture #(
      .DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .WRAP_MODE(0), .DROP_W(DROP_W)
   ) u_dut (
      .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
      .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .rd_valid(rv0), .rd_ready(rd_ready),
      .rd_data(rdata0), .rd_count(rcount0), .fill_level(fill0),
      .drop_count(drop0), .capturing(cap0), .done(done0)
   );

   mynios2_cpu_oci_trace_capture #(
      .DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .WRAP_MODE(1), .DROP_W(DROP_W)
   ) u_dut_ring (
      .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
      .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .rd_valid(rv1), .rd_ready(rd_ready),
      .rd_data(rdata1), .rd_count(rcount1), .fill_level(fill1),
      .drop_count(drop1), .capturing(cap1), .done(done1)
   );

   // ---------------- scoreboard / reference queues ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   int exp_drop0 = 0;
   int exp_drop1 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      exp_q0.delete();
      exp_q1.delete();
      exp_drop0 = 0;
      exp_drop1 = 0;
   endtask

   // Stop-on-full keeps the first DEPTH frames; ring keeps the last DEPTH.
   task automatic model_frame(input logic [DATA_W-1:0] d, input logic [COUNT_W-1:0] t);
      trace_entry_t e;
      e.tag  = t;
      e.data = d;
      if (exp_q0.size() < DEPTH) exp_q0.push_back(e);
      else if (exp_drop0 < DROP_MAX) exp_drop0++;
      if (exp_q1.size() == DEPTH) begin
         void'(exp_q1.pop_front());
         if (exp_drop1 < DROP_MAX) exp_drop1++;
      end
      exp_q1.push_back(e);
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic [COUNT_W-1:0] t);
      dct_valid  = 1'b1;
      dct_buffer = d;
      dct_count  = t;
      model_frame(d, t);
      cycle();
      dct_valid = 1'b0;
   endtask

   task automatic arm_capture();
      arm = 1'b1;
      cycle();
      arm = 1'b0;
      model_clear();
   endtask

   task automatic freeze();
      test_ending = 1'b1;
      cycle();
      test_ending = 1'b0;
   endtask

   task automatic pop_compare(input string tag);
      if (rv0 && rd_ready) begin
         if (exp_q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_pop0: got 0x%0h, expected no entry", tag, {rcount0, rdata0});
         end else check({tag, "_pop0"}, {rcount0, rdata0}, exp_q0.pop_front());
      end
      if (rv1 && rd_ready) begin
         if (exp_q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_pop1: got 0x%0h, expected no entry", tag, {rcount1, rdata1});
         end else check({tag, "_pop1"}, {rcount1, rdata1}, exp_q1.pop_front());
      end
   endtask

   task automatic drain_all(input bit toggle, input string tag);
      for (int c = 0; c < 400; c++) begin
         if (done0 && done1) break;
         rd_ready = toggle ? ($urandom_range(0, 1) == 1) : 1'b1;
         pop_compare(tag);
         cycle();
      end
      rd_ready = 1'b0;
      check({tag, "_done0"}, done0, 1);
      check({tag, "_done1"}, done1, 1);
      check({tag, "_left0"}, exp_q0.size(), 0);
      check({tag, "_left1"}, exp_q1.size(), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic arm, dv;
      logic [DATA_W-1:0] data;
      logic [COUNT_W-1:0] tag;
      logic te, the, rdy;
      logic rv;
      logic [DATA_W-1:0] rdata;
      logic [COUNT_W-1:0] rcount;
      logic [FILL_W-1:0] fill;
      logic [DROP_W-1:0] drop;
      logic cap, dn;
   } vec_t;

   function automatic vec_t mk(input logic a, input logic dv, input int data, input int tag,
                               input logic te, input logic the, input logic rdy,
                               input logic rv, input int rdata, input int rcount,
                               input int fill, input int drop, input logic cap, input logic dn);
      vec_t v;
      v.arm = a; v.dv = dv; v.data = DATA_W'(data); v.tag = COUNT_W'(tag);
      v.te = te; v.the = the; v.rdy = rdy;
      v.rv = rv; v.rdata = DATA_W'(rdata); v.rcount = COUNT_W'(rcount);
      v.fill = FILL_W'(fill); v.drop = DROP_W'(drop); v.cap = cap; v.dn = dn;
      return v;
   endfunction

   vec_t vecs[14];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; arm = 1'b0; dct_valid = 1'b0; test_ending = 1'b0;
      test_has_ended = 1'b0; rd_ready = 1'b0; dct_buffer = '0; dct_count = '0;

      //           arm dv data tag te the rdy | rv rdata rcnt fill drop cap done
      vecs[0]  = mk(1, 0, 0,   0,  0, 0,  0,    0, 0,    0,   0,   0,   1,  0);
      vecs[1]  = mk(0, 1, 1,   1,  0, 0,  0,    0, 0,    0,   1,   0,   1,  0);
      vecs[2]  = mk(0, 1, 2,   2,  0, 0,  0,    0, 0,    0,   2,   0,   1,  0);
      vecs[3]  = mk(0, 1, 3,   3,  0, 0,  0,    0, 0,    0,   3,   0,   1,  0);
      vecs[4]  = mk(0, 1, 4,   4,  0, 0,  0,    0, 0,    0,   4,   0,   1,  0);
      vecs[5]  = mk(0, 1, 5,   5,  0, 0,  0,    0, 0,    0,   5,   0,   1,  0);
      vecs[6]  = mk(0, 0, 0,   0,  1, 0,  0,    1, 1,    1,   5,   0,   0,  0);
      vecs[7]  = mk(0, 0, 0,   0,  0, 0,  1,    1, 2,    2,   4,   0,   0,  0);
      vecs[8]  = mk(0, 0, 0,   0,  0, 0,  1,    1, 3,    3,   3,   0,   0,  0);
      vecs[9]  = mk(0, 0, 0,   0,  0, 0,  1,    1, 4,    4,   2,   0,   0,  0);
      vecs[10] = mk(0, 0, 0,   0,  0, 0,  1,    1, 5,    5,   1,   0,   0,  0);
      vecs[11] = mk(0, 0, 0,   0,  0, 0,  1,    0, 0,    0,   0,   0,   0,  0);
      vecs[12] = mk(0, 0, 0,   0,  0, 0,  0,    0, 0,    0,   0,   0,   0,  1);
      vecs[13] = mk(0, 1, 9,   9,  0, 0,  1,    0, 0,    0,   0,   0,   0,  1);

      // Reset state
      repeat (3) cycle();
      check("rst_rd_valid", rv0, 0);
      check("rst_rd_data", rdata0, 0);
      check("rst_rd_count", rcount0, 0);
      check("rst_fill", fill0, 0);
      check("rst_drop", drop0, 0);
      check("rst_capturing", cap0, 0);
      check("rst_done", done0, 0);
      check("rst_capturing_ring", cap1, 0);
      reset = 1'b0;

      // IDLE ignores frames
      dct_valid = 1'b1; dct_buffer = 30'h77; cycle(); dct_valid = 1'b0;
      check("idle_fill", fill0, 0);

      // Five frames, freeze, drain at full rate
      for (int i = 0; i < 14; i++) begin
         arm = vecs[i].arm; dct_valid = vecs[i].dv; dct_buffer = vecs[i].data;
         dct_count = vecs[i].tag; test_ending = vecs[i].te;
         test_has_ended = vecs[i].the; rd_ready = vecs[i].rdy;
         cycle();
         check($sformatf("v%0d_rd_valid", i), rv0, vecs[i].rv);
         check($sformatf("v%0d_rd_data", i), rdata0, vecs[i].rdata);
         check($sformatf("v%0d_rd_count", i), rcount0, vecs[i].rcount);
         check($sformatf("v%0d_fill", i), fill0, vecs[i].fill);
         check($sformatf("v%0d_drop", i), drop0, vecs[i].drop);
         check($sformatf("v%0d_capturing", i), cap0, vecs[i].cap);
         check($sformatf("v%0d_done", i), done0, vecs[i].dn);
         check($sformatf("v%0d_ring_rd_data", i), rdata1, vecs[i].rdata);
         check($sformatf("v%0d_ring_fill", i), fill1, vecs[i].fill);
         check($sformatf("v%0d_ring_done", i), done1, vecs[i].dn);
      end
      arm = 1'b0; dct_valid = 1'b0; rd_ready = 1'b0;

      // 20 frames into 16 entries: stop-on-full keeps 0..15, ring keeps 4..19
      arm_capture();
      for (int i = 0; i < 20; i++) send_frame(DATA_W'(i), COUNT_W'(i));
      check("ovf_fill", fill0, DEPTH);
      check("ovf_fill_ring", fill1, DEPTH);
      check("ovf_drop", drop0, exp_drop0);
      check("ovf_drop_ring", drop1, exp_drop1);
      check("ovf_drop_is_4", drop0, 4);
      freeze();
      check("ovf_first_rd_valid", rv0, 1);
      check("ovf_first_head_ring", rdata1, 4);
      drain_all(1'b0, "ovf");
      check("ovf_drop_after", drop0, 4);
      check("ovf_drop_after_ring", drop1, 4);

      // Frame on the freeze cycle is kept; a frame during DRAIN is neither kept nor counted
      arm_capture();
      dct_valid = 1'b1; dct_buffer = 30'h2A; dct_count = 4'h5; test_ending = 1'b1;
      model_frame(30'h2A, 4'h5);
      cycle();
      dct_valid = 1'b0; test_ending = 1'b0;
      check("same_fill", fill0, 1);
      check("same_capturing", cap0, 0);
      check("same_head", rdata0, 30'h2A);
      dct_valid = 1'b1; dct_buffer = 30'h3B;
      cycle();
      dct_valid = 1'b0;
      check("drain_frame_fill", fill0, 1);
      check("drain_frame_drop", drop0, 0);
      drain_all(1'b0, "same");

      // Abort with 3 entries left, then re-arm
      arm_capture();
      for (int i = 0; i < 10; i++) send_frame(DATA_W'(32'h100 + i), COUNT_W'(i));
      freeze();
      rd_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         check($sformatf("abort_rv_%0d", k), rv0, 1);
         pop_compare("abort");
         cycle();
      end
      rd_ready = 1'b0;
      check("abort_fill_left", fill0, 3);
      test_has_ended = 1'b1;
      cycle();
      test_has_ended = 1'b0;
      check("abort_done", done0, 1);
      check("abort_rd_valid", rv0, 0);
      check("abort_done_ring", done1, 1);
      arm_capture();
      check("rearm_capturing", cap0, 1);
      check("rearm_fill", fill0, 0);
      check("rearm_drop", drop0, 0);
      check("rearm_done", done0, 0);

      // test_has_ended outranks test_ending in CAPTURE
      send_frame(30'h11, 4'h1);
      send_frame(30'h12, 4'h2);
      test_ending = 1'b1; test_has_ended = 1'b1;
      cycle();
      test_ending = 1'b0; test_has_ended = 1'b0;
      check("prio_done", done0, 1);
      check("prio_rd_valid", rv0, 0);
      cycle();
      check("prio_hold_fill", fill0, 2);
      check("prio_hold_done", done0, 1);

      // 300 frames: drop counter saturates; drain with a random ready pattern
      arm_capture();
      for (int i = 0; i < 300; i++)
         send_frame(DATA_W'($urandom), COUNT_W'($urandom_range(0, 15)));
      check("sat_drop", drop0, DROP_MAX);
      check("sat_drop_ring", drop1, DROP_MAX);
      check("sat_fill", fill0, DEPTH);
      freeze();
      drain_all(1'b1, "sat");
      check("sat_drop_after", drop0, DROP_MAX);

      // Reset in the middle of a drain
      arm_capture();
      for (int i = 0; i < 3; i++) send_frame(DATA_W'(32'h200 + i), COUNT_W'(i));
      freeze();
      rd_ready = 1'b1;
      cycle();
      rd_ready = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      model_clear();
      check("mid_rst_fill", fill0, 0);
      check("mid_rst_rd_valid", rv0, 0);
      check("mid_rst_rd_data", rdata0, 0);
      check("mid_rst_capturing", cap0, 0);
      check("mid_rst_done", done0, 0);
      check("mid_rst_fill_ring", fill1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
